// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the mov/moc memory initiator.
//   - size encodings carried on req_size / mem_typeData
//   - FSM state enum for mem_initiator
//   - default address limit and timeout depth
//   - size_bytes(): number of bytes touched by an access, used by the
//     address limit check
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEFAULT_ADDR_LIMIT     = 256;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER,
    ST_ERR
  } mem_state_e;

  // Reserved size returns 0; callers reject that size before using the count.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_rdata_align.sv
// mem_rdata_align: selects the right-aligned load field for the access size
// and zero- or sign-extends it to 32 bits. Purely combinational, so the
// core's load path can share it.
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext  in  1   1 = sign-extend, 0 = zero-extend
//   raw       in  32  data as returned by the RAM (right-aligned)
//   data      out 32  extended load value
module mem_rdata_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{sign_ext & raw[7]}},  raw[7:0]};
      SZ_HALF: data = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: initiator side of the four-phase mov/moc RAM handshake.
// Takes one load/store at a time from the core, checks it, drives the RAM
// bus (SETUP), raises mov (STROBE) until moc, then waits for moc to fall
// (RECOVER) before accepting the next request. Illegal requests get a
// one-cycle error response without touching the bus.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   - STROBE and RECOVER waits are bounded by TIMEOUT_CYCLES;
//               expiry sets the sticky bus_fault flag (STROBE expiry also
//               returns an error response).
//   undefined - waits are unbounded and bus_fault is tied 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request from the core (req_ready high only in IDLE)
//   rsp_valid/err     one-cycle completion pulse, error qualifier
//   rsp_rdata         extended load data, 0 for stores and errors
//   mem_address/rw/typeData/wdata   RAM bus, held from SETUP to RECOVER
//   mem_rdata         RAM read data
//   mem_mov/mem_moc   handshake strobe / completion
//   bus_fault         sticky timeout flag
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT     = DEFAULT_ADDR_LIMIT,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_rw,
  output logic [1:0]  mem_typeData,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_mov,
  input  logic        mem_moc,
  output logic        bus_fault
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_e  state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_rw_q, mem_rw_d;
  logic [1:0]  mem_type_data_q, mem_type_data_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        sign_q, sign_d;
  logic        mem_mov_q, mem_mov_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [32:0] last_byte;
  logic        illegal;
  logic [31:0] load_data;

  // 33-bit sum so an address near 2^32 cannot wrap below the limit.
  assign last_byte = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;

  assign illegal = (req_size == 2'b11)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || (last_byte >= 33'(ADDR_LIMIT));

  mem_rdata_align u_align (
    .size     (mem_type_data_q),
    .sign_ext (sign_q),
    .raw      (mem_rdata),
    .data     (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_fault_q, bus_fault_d;
  logic             expired;

  // True on the last permitted cycle of a wait.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d         = state_q;
    mem_address_d   = mem_address_q;
    mem_rw_d        = mem_rw_q;
    mem_type_data_d = mem_type_data_q;
    mem_wdata_d     = mem_wdata_q;
    sign_d          = sign_q;
    rsp_valid_d     = 1'b0;
    rsp_err_d       = 1'b0;
    rsp_rdata_d     = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d           = cnt_q;
    bus_fault_d     = bus_fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            // Response is registered so it coincides with the ERR cycle;
            // bus registers are left untouched.
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d         = ST_SETUP;
            mem_address_d   = req_addr;
            mem_rw_d        = ~req_write;
            mem_type_data_d = req_size;
            mem_wdata_d     = req_wdata;
            sign_d          = req_signed;
          end
        end
      end

      ST_ERR: state_d = ST_IDLE;

      ST_SETUP: begin
        state_d = ST_STROBE;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      ST_STROBE: begin
        if (mem_moc) begin
          state_d     = ST_RECOVER;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rw_q ? load_data : '0;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
        end else if (expired) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          bus_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      ST_RECOVER: begin
        if (!mem_moc) begin
          state_d = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (expired) begin
          state_d     = ST_IDLE;
          bus_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // mov is registered from the next state so it is glitch-free and
    // falls in the same edge that leaves STROBE.
    mem_mov_d = (state_d == ST_STROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mem_address_q   <= '0;
      mem_rw_q        <= 1'b1;
      mem_type_data_q <= 2'b00;
      mem_wdata_q     <= '0;
      sign_q          <= 1'b0;
      mem_mov_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      mem_address_q   <= mem_address_d;
      mem_rw_q        <= mem_rw_d;
      mem_type_data_q <= mem_type_data_d;
      mem_wdata_q     <= mem_wdata_d;
      sign_q          <= sign_d;
      mem_mov_q       <= mem_mov_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_rdata_q     <= rsp_rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bus_fault_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_fault_q <= bus_fault_d;
    end
  end

  assign bus_fault = bus_fault_q;
`else
  assign bus_fault = 1'b0;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mem_address  = mem_address_q;
  assign mem_rw       = mem_rw_q;
  assign mem_typeData = mem_type_data_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_mov      = mem_mov_q;

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Initiator end of the mov/moc memory handshake: accepts single load/store requests from the core, drives address, rw, typeData and write data to the byte-addressed 256x8 RAM, and completes a four-phase mov/moc exchange. Read data is extracted big-endian and zero- or sign-extended. Illegal requests, and stalled transfers when enabled, return an error response. Sits between the core's load/store unit and the RAM.

## Interface
- ADDR_LIMIT, 256: first illegal byte address; any accessed byte at or above it is an error.
- TIMEOUT_CYCLES, 16: maximum cycles spent waiting on moc per phase (only with MEM_TIMEOUT_EN).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load data.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid.
- mem_address  out  32  to RAM address.
- mem_rw  out  1  1 = read, 0 = write.
- mem_typeData  out  2  equals accepted req_size.
- mem_wdata  out  32  to RAM DataIn.
- mem_rdata  in  32  from RAM DataOut.
- mem_mov  out  1  strobe to RAM.
- mem_moc  in  1  completion from RAM.
- bus_fault  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0).

## Operation
- States: IDLE, SETUP, STROBE, RECOVER, ERR.
- IDLE: when req_valid is high, register the request.
  - Illegal request → ERR. Illegal means: size 11; halfword with addr[0]≠0; word with addr[1:0]≠0; or addr+bytes−1 ≥ ADDR_LIMIT.
  - Legal request → SETUP.
- ERR: rsp_valid=1, rsp_err=1 for one cycle, then IDLE. No bus signal changes; mem_mov stays 0.
- SETUP: mem_address, mem_rw, mem_typeData and mem_wdata are driven stable with mem_mov=0 for one cycle, then STROBE.
- STROBE: mem_mov=1. When mem_moc is sampled high:
  - For loads, capture mem_rdata: byte uses [7:0], halfword [15:0], word [31:0]. Extend with sign if req_signed, else zero.
  - Pulse rsp_valid with rsp_err=0, drop mem_mov, go to RECOVER.
- RECOVER: mem_mov=0. Wait until mem_moc is sampled low, then IDLE. This guarantees a fresh moc edge for the next STROBE.
- Bus outputs hold their values from SETUP through RECOVER.
- Reset values: state IDLE, mem_mov 0, mem_rw 1 (read, so no spurious write), mem_address 0, mem_typeData 00, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, bus_fault 0.
- Reset mid-transfer: mem_mov drops immediately (asynchronous), and no response is issued.

## Timing
- Acceptance occurs at the edge where req_valid && req_ready.
- Minimum legal latency is 3 edges from acceptance to rsp_valid: SETUP, STROBE, then moc sampled.
- Error latency is 1 edge.
- Back-to-back throughput is at best one request per 4 cycles, since RECOVER lasts at least one cycle.
- mem_moc is sampled only in STROBE and RECOVER; a moc already high on entry to STROBE is impossible by construction.
- rsp_valid is exactly one cycle wide. The core must accept it; there is no backpressure.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in STROBE and in RECOVER and resets on each state entry.
  - If TIMEOUT_CYCLES elapse in STROBE, drop mem_mov, pulse rsp_valid with rsp_err=1, set bus_fault, and go to IDLE.
  - If TIMEOUT_CYCLES elapse in RECOVER, set bus_fault and go to IDLE with no extra response.
  - bus_fault clears only on reset.
- MEM_TIMEOUT_EN undefined: no counter exists, waits are unbounded, and bus_fault is constant 0.

## Structure
- Package mem_if_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - the default ADDR_LIMIT;
  - the byte-count function used by the limit check.
- Sub-module mem_rdata_align: combinational size select plus sign/zero extension, reused by the core's load path.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load from 0x10 → mem_wdata 0xDEADBEEF, mem_rw 0 then 1, rsp_rdata 0xDEADBEEF, rsp_err 0, latency 3 with immediate moc.
- Byte store 0x80 at 0x05, then signed byte load → 0xFFFFFF80; unsigned byte load → 0x00000080.
- Halfword at 0x03, word at 0x02, size 11, and word at 0xFE → each gives an ERR pulse one cycle after acceptance; mem_mov never rises.
- Responder holds moc 5 cycles before rising and 3 cycles before falling → mem_mov high until moc, req_ready low until moc returns low, exactly one rsp_valid.
- With MEM_TIMEOUT_EN, moc stuck 0 → rsp_err after 16 STROBE cycles and bus_fault=1. Without the macro, the block stays in STROBE indefinitely.
- rst_n low in STROBE → mem_mov 0 asynchronously, no rsp_valid, req_ready 1 after release.
